interrupt_controller: RTL and testbench

- Sits directly downstream of the per-line interrupt_handler instances.
- Collects their int_request levels, synchronises them to clk, and selects one by fixed priority.
- Presents the selected source to the CPU with an irq/ack/done handshake.
- After the CPU signals end-of-interrupt, returns int_handled to the serviced source so that source's int_request clears.

---
 rtl/intc_pkg.sv | 15 +
 rtl/intc_prio_enc.sv | 22 ++
 rtl/interrupt_controller.sv | 128 ++++++++++++
 tb/tb_interrupt_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: size defaults and FSM encoding.
package intc_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned VEC_W_DEF   = 2;
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2,
    CLEAR   = 2'd3
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: the lowest set index of pending wins.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF
) (
  input  logic [NUM_SRC-1:0] pending,
  output logic               any,
  output logic [VEC_W-1:0]   idx
);

  // Scan from the top so the lowest set bit is the last to overwrite idx.
  always_comb begin
    any = |pending;
    idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending[i]) idx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises per-source request levels, picks the
// lowest-index pending source and runs the irq/ack/done handshake with the
// CPU, then strobes int_handled back to the serviced source.
// Optional per-source masking is enabled by defining INTC_MASK_EN.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_request,
  output logic [NUM_SRC-1:0] int_handled,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   cpu_int_vector,
  input  logic               cpu_int_ack,
  input  logic               cpu_int_done,
`ifdef INTC_MASK_EN
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
`endif
  output logic               busy
);

  logic [NUM_SRC-1:0] req_m;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               any;
  logic [VEC_W-1:0]   win;

  state_t             state;
  state_t             state_d;
  logic [VEC_W-1:0]   vec_d;
  logic               irq_d;
  logic [NUM_SRC-1:0] hnd_d;

  // Two-flop synchroniser for the asynchronous request levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_m <= '0;
      req_s <= '0;
    end else begin
      req_m <= int_request;
      req_s <= req_m;
    end
  end

`ifdef INTC_MASK_EN
  // Software-writable mask; a set bit hides that source from arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask <= '0;
    else if (mask_we) mask <= mask_wdata;
  end
`else
  assign mask = '0;
`endif

  assign pending = req_s & ~mask;

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .pending (pending),
    .any     (any),
    .idx     (win)
  );

  // Next-state and next-output logic; the vector is frozen once latched.
  always_comb begin
    state_d = state;
    vec_d   = cpu_int_vector;
    irq_d   = cpu_irq;
    hnd_d   = int_handled;
    unique case (state)
      IDLE: begin
        if (any) begin
          vec_d   = win;
          irq_d   = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (cpu_int_ack) begin
          irq_d   = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (cpu_int_done) begin
          hnd_d   = NUM_SRC'(1) << cpu_int_vector;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (!req_s[cpu_int_vector]) begin
          hnd_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        hnd_d   = '0;
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cpu_irq        <= 1'b0;
      cpu_int_vector <= '0;
      int_handled    <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      cpu_irq        <= irq_d;
      cpu_int_vector <= vec_d;
      int_handled    <= hnd_d;
      busy           <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
// Define INTC_MASK_EN to exercise the mask ports.
module tb_interrupt_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned VW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  int_request;
  logic [N-1:0]  int_handled;
  logic          cpu_irq;
  logic [VW-1:0] cpu_int_vector;
  logic          cpu_int_ack;
  logic          cpu_int_done;
  logic          busy;
`ifdef INTC_MASK_EN
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
`endif

  interrupt_controller #(.NUM_SRC(N), .VEC_W(VW)) dut (
    .clk            (clk),
    .reset          (reset),
    .int_request    (int_request),
    .int_handled    (int_handled),
    .cpu_irq        (cpu_irq),
    .cpu_int_vector (cpu_int_vector),
    .cpu_int_ack    (cpu_int_ack),
    .cpu_int_done   (cpu_int_done),
`ifdef INTC_MASK_EN
    .mask_we        (mask_we),
    .mask_wdata     (mask_wdata),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int irq_rises = 0;
  logic prev_irq = 1'b0;

  // Model: request delay line, mask, and the transaction in flight.
  logic [N-1:0]  m_d1, m_d2, m_mask, m_hnd;
  logic          m_irq;
  logic [VW-1:0] m_vec;
  int            m_cur;      // serviced source, -1 when idle
  bit            m_wait_done;
  bit            m_wait_drop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_mask = '0; m_hnd = '0;
    m_irq = 1'b0; m_vec = '0; m_cur = -1;
    m_wait_done = 1'b0; m_wait_drop = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge inputs.
  task automatic model_edge();
    logic [N-1:0] pend;
    pend = m_d2 & ~m_mask;
    if (m_cur < 0) begin
      if (pend != '0) begin
        m_cur = lowest(pend);
        m_vec = VW'(m_cur);
        m_irq = 1'b1;
      end
    end else if (m_irq) begin
      if (cpu_int_ack) begin
        m_irq = 1'b0;
        m_wait_done = 1'b1;
      end
    end else if (m_wait_done) begin
      if (cpu_int_done) begin
        m_wait_done = 1'b0;
        m_wait_drop = 1'b1;
        m_hnd = N'(1) << m_cur;
      end
    end else if (m_wait_drop) begin
      if (!m_d2[m_cur]) begin
        m_wait_drop = 1'b0;
        m_hnd = '0;
        m_cur = -1;
      end
    end
`ifdef INTC_MASK_EN
    if (mask_we) m_mask = mask_wdata;
`endif
    m_d2 = m_d1;
    m_d1 = int_request;
  endtask

  task automatic compare_all();
    chk("cpu_irq", 32'(cpu_irq), 32'(m_irq));
    chk("cpu_int_vector", 32'(cpu_int_vector), 32'(m_vec));
    chk("int_handled", 32'(int_handled), 32'(m_hnd));
    chk("busy", 32'(busy), 32'(m_cur >= 0));
    chk("handled_onehot", 32'($countones(int_handled) <= 1), 32'(1));
  endtask

  // Advance one cycle, update the model, check, then let the handlers react.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
    if (cpu_irq && !prev_irq) irq_rises++;
    prev_irq = cpu_irq;
    int_request = int_request & ~m_hnd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_irq", 32'(cpu_irq), 32'(0));
    chk("rst_hnd", 32'(int_handled), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_vec", 32'(cpu_int_vector), 32'(0));
    tick();
    tick();
    reset = 1'b0;
    prev_irq = 1'b0;
  endtask

  task automatic wait_irq(int lim);
    int k = 0;
    while (!m_irq && k < lim) begin tick(); k++; end
    chk("wait_irq", 32'(cpu_irq), 32'(1));
  endtask

  task automatic wait_idle(int lim);
    int k = 0;
    while (m_cur >= 0 && k < lim) begin tick(); k++; end
    chk("wait_idle", 32'(busy), 32'(0));
  endtask

  task automatic pulse_ack();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_int_done = 1'b1; tick(); cpu_int_done = 1'b0;
  endtask

  task automatic serve(int exp_vec);
    wait_irq(20);
    chk("serve_vec", 32'(cpu_int_vector), 32'(exp_vec));
    pulse_ack();
    tick();
    pulse_done();
    chk("serve_hnd", 32'(int_handled), 32'(N'(1) << exp_vec));
    wait_idle(10);
  endtask

  initial begin
    int r0;
    int_request = '0; cpu_int_ack = 1'b0; cpu_int_done = 1'b0;
`ifdef INTC_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    do_reset();

    // Basic flow: fixed 3-edge latency, handshake, clear after drop.
    int_request = 4'b0100;
    tick(); tick();
    chk("t1_irq_early", 32'(cpu_irq), 32'(0));
    tick();
    chk("t1_irq", 32'(cpu_irq), 32'(1));
    chk("t1_vec", 32'(cpu_int_vector), 32'(2));
    pulse_ack();
    chk("t1_ack_irq", 32'(cpu_irq), 32'(0));
    chk("t1_ack_busy", 32'(busy), 32'(1));
    tick();
    pulse_done();
    chk("t1_hnd", 32'(int_handled), 32'(4'b0100));
    tick(); tick(); tick();
    chk("t1_hnd_clr", 32'(int_handled), 32'(0));
    chk("t1_idle", 32'(busy), 32'(0));

    // Priority order: two simultaneous sources, lowest index first.
    r0 = irq_rises;
    int_request = 4'b1010;
    serve(1);
    serve(3);
    repeat (5) tick();
    chk("t2_rises", 32'(irq_rises - r0), 32'(2));

    // No preemption by a higher-priority arrival during SERVICE.
    int_request = 4'b1000;
    wait_irq(20);
    pulse_ack();
    int_request[0] = 1'b1;
    repeat (5) tick();
    chk("t3_vec", 32'(cpu_int_vector), 32'(3));
    chk("t3_hnd0", 32'(int_handled[0]), 32'(0));
    pulse_done();
    wait_idle(10);
    serve(0);

    // Stray handshakes are ignored; ack wins over a simultaneous done.
    cpu_int_ack = 1'b1; cpu_int_done = 1'b1;
    repeat (3) tick();
    cpu_int_ack = 1'b0; cpu_int_done = 1'b0;
    chk("t4_idle", 32'(busy), 32'(0));
    int_request = 4'b0001;
    wait_irq(20);
    cpu_int_done = 1'b1;
    repeat (3) tick();
    cpu_int_done = 1'b0;
    chk("t4_irq_held", 32'(cpu_irq), 32'(1));
    cpu_int_ack = 1'b1; cpu_int_done = 1'b1;
    tick();
    cpu_int_ack = 1'b0; cpu_int_done = 1'b0;
    chk("t4_svc_irq", 32'(cpu_irq), 32'(0));
    chk("t4_svc_hnd", 32'(int_handled), 32'(0));
    tick(); tick();
    chk("t4_svc_hnd2", 32'(int_handled), 32'(0));
    pulse_done();
    wait_idle(10);

    // Reset in SERVICE with the request still high.
    int_request = 4'b0010;
    wait_irq(20);
    pulse_ack();
    do_reset();
    tick(); tick();
    chk("t5_irq_early", 32'(cpu_irq), 32'(0));
    tick();
    chk("t5_irq", 32'(cpu_irq), 32'(1));
    chk("t5_vec", 32'(cpu_int_vector), 32'(1));
    pulse_ack();
    tick();
    pulse_done();
    wait_idle(10);

`ifdef INTC_MASK_EN
    // Masked source stays pending until unmasked.
    mask_we = 1'b1; mask_wdata = 4'b0010;
    tick();
    mask_we = 1'b0;
    int_request = 4'b0010;
    repeat (20) tick();
    chk("t6_masked", 32'(cpu_irq), 32'(0));
    mask_we = 1'b1; mask_wdata = '0;
    tick();
    mask_we = 1'b0;
    serve(1);
`endif

    // Randomized traffic, including premature drops and occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0)
        int_request = int_request | (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 40) == 0)
        int_request = int_request & ~(N'(1) << $urandom_range(0, N - 1));
      cpu_int_ack  = ($urandom_range(0, 3) == 0);
      cpu_int_done = ($urandom_range(0, 3) == 0);
`ifdef INTC_MASK_EN
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = N'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 200) == 0) do_reset();
      tick();
    end
    cpu_int_ack = 1'b0; cpu_int_done = 1'b0;
`ifdef INTC_MASK_EN
    mask_we = 1'b0;
`endif
    int_request = '0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
